shared_reg_arbiter: RTL and testbench
=====================================

SHARED_REG_ARBITER -- requirements
Module: shared_reg_arbiter

Interface
REQ-001 Parameter Width, default 6: bit width of each requester's data word and of the shared register.
REQ-002 Parameter N, default 4: number of requesters, legal range 2..8.
REQ-003 Parameter MaxHold, default 3: maximum consecutive load cycles per grant, legal range 1..15.
REQ-004 clk  input  1: single clock; all state updates on rising edge.
REQ-005 asyn_rst  input  1: reset, asynchronous and active-high.
REQ-006 req  input  N: per-requester load request, level-sensitive.
REQ-007 data_in  input  N*Width: packed request words; requester i at bits [i*Width +: Width].
REQ-008 grant  output  N: registered one-hot grant, all-zero when no owner.
REQ-009 owner  output  3: registered index of current owner, 0 when idle.
REQ-010 data_out  output  Width: shared register contents.
REQ-011 valid_out  output  1: high for each cycle in which data_out was loaded on the preceding edge.

Function
REQ-012 The block SHALL implement a two-state FSM: IDLE and BUSY.
REQ-013 IDLE, req nonzero at an edge: select winner, go to BUSY, grant<=onehot(winner), owner<=winner, data_out<=data_in[winner], valid_out<=1, hold_cnt<=1.
REQ-014 IDLE, req all-zero: stay IDLE, grant=0, valid_out=0, data_out retains its value.
REQ-015 BUSY, req[owner]=1 and hold_cnt<MaxHold: stay BUSY, data_out<=data_in[owner], valid_out<=1, hold_cnt+1.
REQ-016 BUSY, req[owner]=0 or hold_cnt=MaxHold: release; go to IDLE, grant<=0, valid_out<=0, data_out held, rr_ptr<=(owner+1) mod N.
REQ-017 Every release SHALL cost exactly one IDLE cycle before any new grant (re-grant gap of 1 cycle).
REQ-018 Round-robin winner SHALL be the first set req bit searching upward from rr_ptr with wrap-around from N-1 to 0.
REQ-019 Requests from non-owners during BUSY SHALL be ignored and SHALL NOT alter data_out.
REQ-020 grant SHALL never have more than one bit set; grant nonzero iff state is BUSY.
REQ-021 Latency req-to-data_out: 1 edge from IDLE; req deassert-to-release: 1 edge.
REQ-022 hold_cnt SHALL be 4 bits and never exceed MaxHold.

Reset
REQ-023 asyn_rst=1 SHALL immediately force state=IDLE, grant=0, owner=0, data_out=0, valid_out=0, hold_cnt=0, rr_ptr=0, regardless of clk, including mid-BUSY.
REQ-024 Reset SHALL dominate any simultaneous req; first grant is possible on the first rising edge with asyn_rst=0.

Configuration
REQ-025 Macro SHARED_REG_FIXED_PRIORITY_EN defined: winner SHALL be the lowest-index set req bit; rr_ptr not implemented.
REQ-026 Macro undefined: round-robin per REQ-018; MaxHold forced release applies in both builds.

Structure
REQ-027 Package shared_reg_pkg SHALL hold the state enum (IDLE, BUSY), default Width/N/MaxHold constants and the hold-counter width.
REQ-028 Winner selection SHALL be a combinational sub-module rr_pick (inputs req, rr_ptr; outputs winner index, any_req).
REQ-029 data_out register SHALL be inline in shared_reg_arbiter, not a separate instance.

Verification (Width=6, N=4, MaxHold=3)
REQ-030 Reset mid-BUSY: owner=2, data_out=6'b101010, assert asyn_rst between edges -> grant=0, data_out=0, valid_out=0 before next edge.
REQ-031 Single requester: req=4'b0010 held 5 cycles, data_in[1]=6'b010101 -> grant=4'b0010 for 3 edges, 1 IDLE cycle, re-grant on edge 5.
REQ-032 Round-robin: req=4'b1111 constant -> grant sequence 0001,0000,0010,0000,0100,0000,1000,0000,0001 (each grant 3 cycles).
REQ-033 Early release: owner 0, req[0] drops after 1 load -> IDLE next edge, then grant=4'b0010 if req[1]=1; data_out holds last owner-0 value in gap.
REQ-034 Wrap-around: rr_ptr=3, req=4'b0001 -> grant=4'b0001, owner=0.
REQ-035 With SHARED_REG_FIXED_PRIORITY_EN: req=4'b1010 constant -> grant always 4'b0010, never 4'b1000.

Source files
------------

// File: rtl/shared_reg_pkg.sv
// rtl/shared_reg_pkg.sv - shared types and default sizing for the shared register arbiter
package shared_reg_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam int DEF_WIDTH    = 6;
  localparam int DEF_N        = 4;
  localparam int DEF_MAX_HOLD = 3;
  localparam int HOLD_W       = 4;
  localparam int IDX_W        = 3;

endpackage

// File: rtl/shared_reg_arbiter_rr_pick.sv
// rtl/shared_reg_arbiter_rr_pick.sv - combinational winner search upward from rr_ptr with wrap
module rr_pick
  import shared_reg_pkg::*;
#(
  parameter int N = DEF_N
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [IDX_W-1:0] winner,
  output logic             any_req
);

  logic [N-1:0]     rot;
  logic [IDX_W-1:0] off;
  logic [IDX_W:0]   sum;

  // Rotating the doubled vector puts rr_ptr at bit 0, so the lowest set bit is the winner offset.
  always_comb begin
    any_req = |req;
    rot     = N'({req, req} >> rr_ptr);
    off     = '0;
    for (int j = N - 1; j >= 0; j--) begin
      if (rot[j]) off = IDX_W'(j);
    end
    sum = {1'b0, rr_ptr} + {1'b0, off};
    if (sum >= (IDX_W + 1)'(N)) sum = sum - (IDX_W + 1)'(N);
    winner = sum[IDX_W-1:0];
  end

endmodule

// File: rtl/shared_reg_arbiter.sv
// rtl/shared_reg_arbiter.sv - N-way arbiter loading one shared register, bounded hold per grant
// SHARED_REG_FIXED_PRIORITY_EN selects lowest-index priority instead of round-robin.
module shared_reg_arbiter
  import shared_reg_pkg::*;
#(
  parameter int Width   = DEF_WIDTH,
  parameter int N       = DEF_N,
  parameter int MaxHold = DEF_MAX_HOLD
) (
  input  logic               clk,
  input  logic               asyn_rst,
  input  logic [N-1:0]       req,
  input  logic [N*Width-1:0] data_in,
  output logic [N-1:0]       grant,
  output logic [2:0]         owner,
  output logic [Width-1:0]   data_out,
  output logic               valid_out
);

  state_t            state;
  logic [HOLD_W-1:0] hold_cnt;
  logic [IDX_W-1:0]  rr_ptr;
  logic [IDX_W-1:0]  winner;
  logic              any_req;
  logic [Width-1:0]  win_word;
  logic [Width-1:0]  own_word;
  logic              own_req;
  logic [N-1:0]      win_onehot;

`ifdef SHARED_REG_FIXED_PRIORITY_EN
  assign rr_ptr = '0;
`else
  logic [IDX_W-1:0] next_ptr;

  always_comb begin
    next_ptr = (owner == IDX_W'(N - 1)) ? '0 : owner + IDX_W'(1);
  end
`endif

  rr_pick #(
    .N(N)
  ) u_rr_pick (
    .req    (req),
    .rr_ptr (rr_ptr),
    .winner (winner),
    .any_req(any_req)
  );

  always_comb begin
    win_word   = '0;
    own_word   = '0;
    own_req    = 1'b0;
    win_onehot = '0;
    for (int i = 0; i < N; i++) begin
      if (winner == IDX_W'(i)) begin
        win_word      = data_in[i*Width +: Width];
        win_onehot[i] = 1'b1;
      end
      if (owner == IDX_W'(i)) begin
        own_word = data_in[i*Width +: Width];
        own_req  = req[i];
      end
    end
  end

  always_ff @(posedge clk or posedge asyn_rst) begin
    if (asyn_rst) begin
      state     <= IDLE;
      grant     <= '0;
      owner     <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
      hold_cnt  <= '0;
`ifndef SHARED_REG_FIXED_PRIORITY_EN
      rr_ptr    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            state     <= BUSY;
            grant     <= win_onehot;
            owner     <= winner;
            data_out  <= win_word;
            valid_out <= 1'b1;
            hold_cnt  <= HOLD_W'(1);
          end else begin
            grant     <= '0;
            valid_out <= 1'b0;
            hold_cnt  <= '0;
          end
        end
        BUSY: begin
          // Non-owner requests are invisible here; only the owner's word can load.
          if (own_req && (hold_cnt < HOLD_W'(MaxHold))) begin
            data_out  <= own_word;
            valid_out <= 1'b1;
            hold_cnt  <= hold_cnt + HOLD_W'(1);
          end else begin
            state     <= IDLE;
            grant     <= '0;
            owner     <= '0;
            valid_out <= 1'b0;
            hold_cnt  <= '0;
`ifndef SHARED_REG_FIXED_PRIORITY_EN
            rr_ptr    <= next_ptr;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// tb/tb_shared_reg_arbiter.sv - table-driven directed bench for shared_reg_arbiter (Width=6, N=4, MaxHold=3)
module tb_shared_reg_arbiter;

  logic        clk;
  logic        asyn_rst;
  logic [3:0]  req;
  logic [23:0] data_in;
  logic [3:0]  grant;
  logic [2:0]  owner;
  logic [5:0]  data_out;
  logic        valid_out;

  int total;
  int bad;

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [23:0] din;
    logic [3:0]  g;
    logic [2:0]  o;
    logic [5:0]  d;
    logic        v;
  } row_t;

  row_t rows[$];

  shared_reg_arbiter #(
    .Width  (6),
    .N      (4),
    .MaxHold(3)
  ) dut (
    .clk      (clk),
    .asyn_rst (asyn_rst),
    .req      (req),
    .data_in  (data_in),
    .grant    (grant),
    .owner    (owner),
    .data_out (data_out),
    .valid_out(valid_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [23:0] mk(input logic [5:0] w0, w1, w2, w3);
    return {w3, w2, w1, w0};
  endfunction

  task automatic add(input logic rst, input logic [3:0] rq, input logic [23:0] din,
                     input logic [3:0] g, input logic [2:0] o, input logic [5:0] d, input logic v);
    row_t r;
    r.rst = rst; r.req = rq; r.din = din; r.g = g; r.o = o; r.d = d; r.v = v;
    rows.push_back(r);
  endtask

  task automatic chk(input string nm, input logic [3:0] g, input logic [2:0] o,
                     input logic [5:0] d, input logic v);
    total++;
    if ({grant, owner, data_out, valid_out} !== {g, o, d, v}) begin
      bad++;
      $display("FAIL %s: got grant=%b owner=%0d data=%h valid=%b, want grant=%b owner=%0d data=%h valid=%b",
               nm, grant, owner, data_out, valid_out, g, o, d, v);
    end
  endtask

  logic [23:0] d0, d1, d2;

  initial begin
    total = 0;
    bad   = 0;
    d0 = mk(6'h11, 6'h15, 6'h2A, 6'h33);
    d1 = mk(6'h11, 6'h0C, 6'h2A, 6'h33);
    d2 = mk(6'h3F, 6'h0C, 6'h01, 6'h33);

`ifdef SHARED_REG_FIXED_PRIORITY_EN
    add(1, 4'b0000, d0, 4'b0000, 0, 6'h00, 0);
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < 3; c++) add(0, 4'b1010, d0, 4'b0010, 1, 6'h15, 1);
      add(0, 4'b1010, d0, 4'b0000, 0, 6'h15, 0);
    end
    add(0, 4'b1010, d0, 4'b0010, 1, 6'h15, 1);
`else
    add(1, 4'b0000, d0, 4'b0000, 0, 6'h00, 0);
    // single requester: three loads, one idle gap, re-grant
    add(0, 4'b0010, d0, 4'b0010, 1, 6'h15, 1);
    add(0, 4'b0010, d1, 4'b0010, 1, 6'h0C, 1);
    add(0, 4'b0010, d0, 4'b0010, 1, 6'h15, 1);
    add(0, 4'b0010, d1, 4'b0000, 0, 6'h15, 0);
    add(0, 4'b0010, d0, 4'b0010, 1, 6'h15, 1);
    add(0, 4'b0000, d1, 4'b0000, 0, 6'h15, 0);
    add(0, 4'b0000, d1, 4'b0000, 0, 6'h15, 0);
    add(1, 4'b0000, d0, 4'b0000, 0, 6'h00, 0);
    // all requesting: rotate 0,1,2,3,0
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < 3; c++)
        add(0, 4'b1111, d0, 4'(1 << k), 3'(k), d0[k*6 +: 6], 1);
      add(0, 4'b1111, d0, 4'b0000, 0, d0[k*6 +: 6], 0);
    end
    add(0, 4'b1111, d0, 4'b0001, 0, 6'h11, 1);
    // early release of owner 0, then owner 1 ignoring others
    add(0, 4'b0010, d0, 4'b0000, 0, 6'h11, 0);
    add(0, 4'b0010, d0, 4'b0010, 1, 6'h15, 1);
    add(0, 4'b1011, d2, 4'b0010, 1, 6'h0C, 1);
    add(0, 4'b0100, d0, 4'b0000, 0, 6'h0C, 0);
    add(0, 4'b0100, d0, 4'b0100, 2, 6'h2A, 1);
    // release of owner 2 leaves rr_ptr=3; requester 0 wins by wrap-around
    add(0, 4'b0000, d0, 4'b0000, 0, 6'h2A, 0);
    add(0, 4'b0001, d0, 4'b0001, 0, 6'h11, 1);
    add(0, 4'b0001, d0, 4'b0001, 0, 6'h11, 1);
`endif

    asyn_rst = 1'b1;
    req      = '0;
    data_in  = d0;
    #2;
    chk("reset_async", 4'b0000, 0, 6'h00, 0);

    foreach (rows[i]) begin
      @(negedge clk);
      asyn_rst = rows[i].rst;
      req      = rows[i].req;
      data_in  = rows[i].din;
      @(posedge clk);
      #1;
      chk($sformatf("row%0d", i), rows[i].g, rows[i].o, rows[i].d, rows[i].v);
    end

    // reset between edges while owner 2 holds 6'b101010
    @(negedge clk);
    asyn_rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    asyn_rst = 1'b0;
    req      = 4'b0100;
    data_in  = d0;
    @(posedge clk);
    #1;
    chk("midbusy_pre", 4'b0100, 2, 6'h2A, 1);
    #2;
    asyn_rst = 1'b1;
    #1;
    chk("midbusy_rst", 4'b0000, 0, 6'h00, 0);
    @(posedge clk);
    #1;
    chk("rst_dominates", 4'b0000, 0, 6'h00, 0);
    @(negedge clk);
    asyn_rst = 1'b0;
    @(posedge clk);
    #1;
    chk("first_edge_grant", 4'b0100, 2, 6'h2A, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
